// File: rtl/isa_pkg.sv
// ISA encodings, ALU op codes and the decoded control bundle shared by the
// decode stage and its combinational decoder.
package isa_pkg;

    localparam int unsigned DEC_W    = 9;
    localparam int unsigned ALU_OP_W = 4;

    typedef enum logic [2:0] {
        OP_ALU  = 3'b000,
        OP_MEM  = 3'b001,
        OP_ADD  = 3'b010,
        OP_ADDI = 3'b011,
        OP_TR   = 3'b100,
        OP_BEQ  = 3'b101,
        OP_SUB  = 3'b110,
        OP_SHF  = 3'b111
    } major_op_e;

    typedef enum logic [1:0] {
        SUB_AND = 2'd0,
        SUB_SLT = 2'd1,
        SUB_OR  = 2'd2,
        SUB_JR  = 2'd3
    } alu_sub_e;

    typedef enum logic [1:0] {
        SUB_LW   = 2'd0,
        SUB_SW   = 2'd1,
        SUB_RSV2 = 2'd2,
        SUB_RSV3 = 2'd3
    } mem_sub_e;

    typedef enum logic [1:0] {
        SUB_SRL  = 2'd0,
        SUB_SRA  = 2'd1,
        SUB_SLL  = 2'd2,
        SUB_HALT = 2'd3
    } shf_sub_e;

    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_JR   = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_CMP  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd10;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                reg_write;
        logic                car_write;
        logic                sel_imm;
        logic                mem_read;
        logic                mem_write;
        logic                mem2reg;
        logic                halt;
        logic                illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational decode of the 9-bit instruction core into control,
// register addresses and immediate; unused fields always drive 0.
module instr_decode
    import isa_pkg::*;
#(
    parameter int unsigned AW      = 4,
    parameter int unsigned REG_W   = 8,
    parameter int unsigned RS_BASE = 4,
    parameter int unsigned RD_BASE = 8,
    parameter int unsigned ACC_REG = 11
) (
    input  logic [DEC_W-1:0] instr,
    output ctrl_t            ctrl_c,
    output logic [AW-1:0]    rs_c,
    output logic [AW-1:0]    rt_c,
    output logic [AW-1:0]    rd_c,
    output logic [REG_W-1:0] imm_c,
    output logic             use_rs_c,
    output logic             use_rt_c
);

    logic [1:0]    fa, fb, fc;
    logic [AW-1:0] rs_sum, rd_sum;

    assign fa     = instr[5:4];
    assign fb     = instr[3:2];
    assign fc     = instr[1:0];
    assign rs_sum = AW'(fa) + AW'(RS_BASE);
    assign rd_sum = AW'(fc) + AW'(RD_BASE);

    always_comb begin
        ctrl_c   = '0;
        rs_c     = '0;
        rt_c     = '0;
        rd_c     = '0;
        imm_c    = '0;
        use_rs_c = 1'b0;
        use_rt_c = 1'b0;
        case (major_op_e'(instr[8:6]))
            OP_ALU: begin
                rs_c             = rs_sum;
                use_rs_c         = 1'b1;
                rd_c             = AW'(ACC_REG);
                ctrl_c.reg_write = 1'b1;
                case (alu_sub_e'(fc))
                    SUB_AND: begin
                        ctrl_c.alu_op = ALU_AND;
                        rt_c          = AW'(fb);
                        use_rt_c      = 1'b1;
                    end
                    SUB_SLT: begin
                        // SLT compares against the upper register bank
                        ctrl_c.alu_op = ALU_SLT;
                        rt_c          = AW'(fb) + AW'(RD_BASE);
                        use_rt_c      = 1'b1;
                    end
                    SUB_OR: begin
                        ctrl_c.alu_op = ALU_OR;
                        rt_c          = AW'(fb);
                        use_rt_c      = 1'b1;
                    end
                    SUB_JR: ctrl_c.alu_op = ALU_JR;
                    default: ;
                endcase
            end
            OP_MEM: begin
                case (mem_sub_e'(fc))
                    SUB_LW: begin
                        ctrl_c.alu_op    = ALU_PASS;
                        rs_c             = rs_sum;
                        use_rs_c         = 1'b1;
                        rd_c             = AW'(fb);
                        ctrl_c.mem_read  = 1'b1;
                        ctrl_c.mem2reg   = 1'b1;
                        ctrl_c.reg_write = 1'b1;
                    end
                    SUB_SW: begin
                        ctrl_c.alu_op    = ALU_PASS;
                        rs_c             = rs_sum;
                        rt_c             = AW'(fb);
                        use_rs_c         = 1'b1;
                        use_rt_c         = 1'b1;
                        ctrl_c.mem_write = 1'b1;
                    end
                    default: ctrl_c.illegal = 1'b1;
                endcase
            end
            OP_ADD, OP_SUB: begin
                ctrl_c.alu_op    = (instr[8:6] == OP_ADD) ? ALU_ADD : ALU_SUB;
                rs_c             = rs_sum;
                rt_c             = AW'(fb);
                rd_c             = rd_sum;
                use_rs_c         = 1'b1;
                use_rt_c         = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.car_write = 1'b1;
            end
            OP_ADDI: begin
                ctrl_c.alu_op    = ALU_ADD;
                rs_c             = rs_sum;
                use_rs_c         = 1'b1;
                rd_c             = AW'(fc);
                imm_c            = REG_W'(fc);
                ctrl_c.sel_imm   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.car_write = 1'b1;
            end
            OP_TR: begin
                ctrl_c.alu_op    = ALU_PASS;
                rs_c             = AW'(instr[2:0]) + AW'(RS_BASE);
                use_rs_c         = 1'b1;
                rd_c             = AW'(instr[5:3]);
                ctrl_c.reg_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_c.alu_op = ALU_CMP;
                rs_c          = rs_sum;
                rt_c          = AW'(fb);
                use_rs_c      = 1'b1;
                use_rt_c      = 1'b1;
            end
            OP_SHF: begin
                if (shf_sub_e'(fc) == SUB_HALT) begin
                    ctrl_c.halt = 1'b1;
                end else begin
                    case (shf_sub_e'(fc))
                        SUB_SRL: ctrl_c.alu_op = ALU_SRL;
                        SUB_SRA: ctrl_c.alu_op = ALU_SRA;
                        default: ctrl_c.alu_op = ALU_SLL;
                    endcase
                    rs_c             = rs_sum;
                    rt_c             = AW'(fb);
                    rd_c             = rs_sum;
                    use_rs_c         = 1'b1;
                    use_rt_c         = 1'b1;
                    ctrl_c.reg_write = 1'b1;
                    ctrl_c.car_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, load-use bubble insertion
// and a sticky halt latch in front of the combinational decoder.
module decode_stage
    import isa_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 12,
    parameter  int unsigned INSTR_W  = 9,
    parameter  int unsigned REG_W    = 8,
    parameter  int unsigned OP_W     = 4,
    parameter  int unsigned RS_BASE  = 4,
    parameter  int unsigned RD_BASE  = 8,
    parameter  int unsigned ACC_REG  = 11,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    alu_op,
    output logic [AW-1:0]      rs_addr,
    output logic [AW-1:0]      rt_addr,
    output logic [AW-1:0]      rd_addr,
    output logic [REG_W-1:0]   imm,
    output logic               reg_write,
    output logic               car_write,
    output logic               sel_imm,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem2reg,
    output logic               halt,
    output logic               illegal,
    output logic               halted
);

    ctrl_t              dec_ctrl_c;
    logic [AW-1:0]      dec_rs_c, dec_rt_c, dec_rd_c;
    logic [REG_W-1:0]   dec_imm_c;
    logic               dec_use_rs_c, dec_use_rt_c;
    logic               hazard_c, accept_c;

    ctrl_t              ctrl_q;
    logic [AW-1:0]      rs_q, rt_q, rd_q;
    logic [REG_W-1:0]   imm_q;
    logic               out_valid_q, halted_q;

    instr_decode #(
        .AW      (AW),
        .REG_W   (REG_W),
        .RS_BASE (RS_BASE),
        .RD_BASE (RD_BASE),
        .ACC_REG (ACC_REG)
    ) u_decode (
        .instr    (instr[DEC_W-1:0]),
        .ctrl_c   (dec_ctrl_c),
        .rs_c     (dec_rs_c),
        .rt_c     (dec_rt_c),
        .rd_c     (dec_rd_c),
        .imm_c    (dec_imm_c),
        .use_rs_c (dec_use_rs_c),
        .use_rt_c (dec_use_rt_c)
    );

    // Load-use: the incoming instruction reads the register a held LW writes
    assign hazard_c = out_valid_q && ctrl_q.mem_read &&
                      ((dec_use_rs_c && (dec_rs_c == rd_q)) ||
                       (dec_use_rt_c && (dec_rt_c == rd_q)));

    assign in_ready = rst_n && !halted_q && !hazard_c && (!out_valid_q || out_ready);
    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else if (accept_c) begin
            ctrl_q      <= dec_ctrl_c;
            rs_q        <= dec_rs_c;
            rt_q        <= dec_rt_c;
            rd_q        <= dec_rd_c;
            imm_q       <= dec_imm_c;
            out_valid_q <= 1'b1;
            if (dec_ctrl_c.halt) begin
                halted_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign alu_op    = OP_W'(ctrl_q.alu_op);
    assign rs_addr   = rs_q;
    assign rt_addr   = rt_q;
    assign rd_addr   = rd_q;
    assign imm       = imm_q;
    assign reg_write = ctrl_q.reg_write;
    assign car_write = ctrl_q.car_write;
    assign sel_imm   = ctrl_q.sel_imm;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign mem2reg   = ctrl_q.mem2reg;
    assign halt      = ctrl_q.halt;
    assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written
// load-use, stall, halt and mid-transfer reset sequences.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] instr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_op;
    logic [3:0] rs_addr, rt_addr, rd_addr;
    logic [7:0] imm;
    logic       reg_write, car_write, sel_imm, mem_read, mem_write, mem2reg;
    logic       halt, illegal, halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .imm       (imm),
        .reg_write (reg_write),
        .car_write (car_write),
        .sel_imm   (sel_imm),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem2reg   (mem2reg),
        .halt      (halt),
        .illegal   (illegal),
        .halted    (halted)
    );

    // {reg_write, car_write, sel_imm, mem_read, mem_write, mem2reg, halt, illegal}
    logic [7:0] flags;
    assign flags = {reg_write, car_write, sel_imm, mem_read, mem_write, mem2reg, halt, illegal};

    typedef struct {
        logic [8:0] instr;
        logic [3:0] op;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [3:0] rd;
        logic [7:0] imm;
        logic [7:0] flags;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{9'b010_01_10_11, 4'd4,  4'd5,  4'd2,  4'd11, 8'd0, 8'b1100_0000}; // ADD
        vecs[1]  = '{9'b000_10_01_00, 4'd0,  4'd6,  4'd1,  4'd11, 8'd0, 8'b1000_0000}; // AND
        vecs[2]  = '{9'b000_01_11_01, 4'd1,  4'd5,  4'd11, 4'd11, 8'd0, 8'b1000_0000}; // SLT
        vecs[3]  = '{9'b000_00_00_10, 4'd2,  4'd4,  4'd0,  4'd11, 8'd0, 8'b1000_0000}; // OR
        vecs[4]  = '{9'b000_11_00_11, 4'd5,  4'd7,  4'd0,  4'd11, 8'd0, 8'b1000_0000}; // JR
        vecs[5]  = '{9'b001_00_10_00, 4'd6,  4'd4,  4'd0,  4'd2,  8'd0, 8'b1001_0100}; // LW
        vecs[6]  = '{9'b001_11_01_01, 4'd6,  4'd7,  4'd1,  4'd0,  8'd0, 8'b0000_1000}; // SW
        vecs[7]  = '{9'b001_00_00_10, 4'd0,  4'd0,  4'd0,  4'd0,  8'd0, 8'b0000_0001}; // illegal
        vecs[8]  = '{9'b001_11_11_11, 4'd0,  4'd0,  4'd0,  4'd0,  8'd0, 8'b0000_0001}; // illegal
        vecs[9]  = '{9'b011_10_00_11, 4'd4,  4'd6,  4'd0,  4'd3,  8'd3, 8'b1110_0000}; // ADDI
        vecs[10] = '{9'b100_101_110,  4'd6,  4'd10, 4'd0,  4'd5,  8'd0, 8'b1000_0000}; // TR
        vecs[11] = '{9'b100_000_111,  4'd6,  4'd11, 4'd0,  4'd0,  8'd0, 8'b1000_0000}; // TR max rs
        vecs[12] = '{9'b101_01_11_00, 4'd7,  4'd5,  4'd3,  4'd0,  8'd0, 8'b0000_0000}; // BEQ
        vecs[13] = '{9'b110_11_11_11, 4'd5,  4'd7,  4'd3,  4'd11, 8'd0, 8'b1100_0000}; // SUB
        vecs[14] = '{9'b111_00_01_00, 4'd8,  4'd4,  4'd1,  4'd4,  8'd0, 8'b1100_0000}; // SRL
        vecs[15] = '{9'b111_11_10_01, 4'd9,  4'd7,  4'd2,  4'd7,  8'd0, 8'b1100_0000}; // SRA
        vecs[16] = '{9'b111_10_00_10, 4'd10, 4'd6,  4'd0,  4'd6,  8'd0, 8'b1100_0000}; // SLL

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 9'b010_01_10_11;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_rd", 32'(rd_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release accepts
        in_valid = 1'b1;
        #1;
        chk("first_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("first_out_valid", 32'(out_valid), 32'd1);
        chk("first_alu_op", 32'(alu_op), 32'd4);
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Decode table
        for (int i = 0; i < 17; i++) begin
            instr    = vecs[i].instr;
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].op));
            chk($sformatf("v%0d_rs", i), 32'(rs_addr), 32'(vecs[i].rs));
            chk($sformatf("v%0d_rt", i), 32'(rt_addr), 32'(vecs[i].rt));
            chk($sformatf("v%0d_rd", i), 32'(rd_addr), 32'(vecs[i].rd));
            chk($sformatf("v%0d_imm", i), 32'(imm), 32'(vecs[i].imm));
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flags));
            step();
        end

        // Load-use: LW r2 then ADD reading r2 via rt -> one bubble
        instr    = 9'b001_00_10_00;
        in_valid = 1'b1;
        step();
        instr = 9'b010_00_10_01;
        #1;
        chk("lu_lw_on_out", 32'(mem_read), 32'd1);
        chk("lu_in_ready_low", 32'(in_ready), 32'd0);
        step();
        chk("lu_bubble", 32'(out_valid), 32'd0);
        chk("lu_in_ready_back", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("lu_add_valid", 32'(out_valid), 32'd1);
        chk("lu_add_op", 32'(alu_op), 32'd4);
        chk("lu_add_rt", 32'(rt_addr), 32'd2);
        step();

        // LW then independent ADD: no hazard, back-to-back
        instr    = 9'b001_00_10_00;
        in_valid = 1'b1;
        step();
        instr = 9'b010_01_00_00;
        #1;
        chk("nohaz_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("nohaz_add_op", 32'(alu_op), 32'd4);
        chk("nohaz_add_rs", 32'(rs_addr), 32'd5);
        step();

        // Stall: ADDI held for 3 cycles, pending ADD not lost
        instr     = 9'b011_00_00_11;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        instr = 9'b010_01_10_11;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_imm", k), 32'(imm), 32'd3);
            chk($sformatf("stall%0d_sel_imm", k), 32'(sel_imm), 32'd1);
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("stall_next_op", 32'(alu_op), 32'd4);
        chk("stall_next_rd", 32'(rd_addr), 32'd11);
        chk("stall_next_sel_imm", 32'(sel_imm), 32'd0);
        step();

        // HALT, then held on output with in_valid asserted for 10 cycles
        instr    = 9'b111_00_00_11;
        in_valid = 1'b1;
        step();
        chk("halt_out", 32'(halt), 32'd1);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_flags", 32'(flags), 32'b0000_0010);
        instr     = 9'b010_01_10_11;
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("halted%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("halted%0d_halt", k), 32'(halt), 32'd1);
            step();
        end

        // Reset mid-transfer with output valid and stalled
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_halted", 32'(halted), 32'd0);
        chk("mrst_halt", 32'(halt), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("mrst_accept_valid", 32'(out_valid), 32'd1);
        chk("mrst_accept_rs", 32'(rs_addr), 32'd5);
        chk("mrst_accept_flags", 32'(flags), 32'b1100_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage between fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and decodes it into ALU/register/memory control fields held in an output register. It inserts a one-cycle bubble on load-use hazards and latches HALT so that no further instructions are accepted until reset.

## Interface
- `NUM_REGS`, 12: register file size; `AW = $clog2(NUM_REGS)`.
- `INSTR_W`, 9: instruction width (≥ 9); only bits [8:0] are decoded.
- `REG_W`, 8: datapath width; width of `imm`.
- `OP_W`, 4: ALU op width.
- `RS_BASE`, 4: offset added to the rs field.
- `RD_BASE`, 8: offset added to the 3-operand rd field.
- `ACC_REG`, 11: implicit destination for AND/SLT/OR/JR.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch has an instruction.
- `in_ready` out 1: stage accepts `instr` this cycle.
- `instr` in INSTR_W: instruction word.
- `out_valid` out 1: decoded control valid.
- `out_ready` in 1: execute consumes.
- `alu_op` out OP_W.
- `rs_addr`, `rt_addr`, `rd_addr` out AW each.
- `imm` out REG_W: zero-extended immediate.
- `reg_write`, `car_write`, `sel_imm`, `mem_read`, `mem_write`, `mem2reg` out 1 each.
- `halt` out 1: decoded instruction is HALT.
- `illegal` out 1: undefined subop; all write enables 0.
- `halted` out 1: sticky; HALT has been accepted.

## Operation
- Fields: op = [8:6], a = [5:4], b = [3:2], c = [1:0].
- Address fields, defined per row: rs = a + RS_BASE; rt = b; rd = c + RD_BASE.
- 000, subop c:
  - AND: op 0.
  - SLT: op 1; rt = b + RD_BASE.
  - OR: op 2.
  - JR: op 5.
  - All four use rd = ACC_REG and reg_write = 1.
- 001, subop c:
  - LW: op 6; rs; rd = b; mem_read = 1; mem2reg = 1; reg_write = 1.
  - SW: op 6; rs; rt; mem_write = 1.
  - Any other c: illegal.
- 010 ADD: op 4; rs; rt; rd; reg_write = 1; car_write = 1.
- 011 ADDI: op 4; rs; rd = c; imm = c; sel_imm = 1; reg_write = 1; car_write = 1.
- 100 TR: op 6; rs = [2:0] + RS_BASE; rd = [5:3]; reg_write = 1.
- 101 BEQ: op 7; rs; rt; no writes.
- 110 SUB: op 5; rs; rt; rd; reg_write = 1; car_write = 1.
- 111, subop c; SRL/SRA/SLL use rs; rt; rd = rs; reg_write = 1; car_write = 1:
  - SRL: op 8.
  - SRA: op 9.
  - SLL: op 10.
  - HALT: halt = 1; no writes.
- Unused address/imm fields drive 0, never X.
- Address sums are computed in AW bits and wrap modulo 2^AW.
- Hazard: `out_valid` and the output holds LW and `instr` reads LW's rd_addr via rs, or via rt where rt is used.
- `in_ready` = `!halted` && `!hazard` && (`!out_valid` || `out_ready`).
- Accept when `in_valid` && `in_ready`: the output register loads the decode result and `out_valid` = 1.
- Else, on `out_ready`: `out_valid` = 0. This is the bubble when a hazard held off the accept.
- Else: output holds; fields remain stable while `out_valid` && !`out_ready`.
- Accepting HALT sets `halted` in the same edge. HALT itself is still presented on the output and drains normally.

## Timing
- Decode latency is 1 cycle: accept at edge N puts the result on the outputs after edge N.
- Throughput is 1 per cycle when there is no hazard and `out_ready` = 1.
- Load-use costs exactly one bubble cycle (`out_valid` = 0) between LW and its dependent instruction.
- Reset, including mid-transfer, drives all outputs and state to 0: `out_valid` = 0, `in_ready` = 0 during reset, `halted` = 0, all control fields 0.
- First accept is possible on the first edge after `rst_n` is released.
- `in_ready` is combinational from `out_valid`, `out_ready`, `halted` and `instr`; it does not depend on `in_valid`.

## Structure
- Package `isa_pkg`:
  - major-opcode and subop enums;
  - ALU op constants (AND 0 … SLL 10);
  - a `ctrl_t` packed struct for the control bundle.
- Sub-module `instr_decode`: purely combinational instr → `ctrl_t`. The stage adds the register, handshake, hazard check and halt latch.

## Test plan
- ADD 9'b010_01_10_11 accepted at N → at N+1: alu_op 4, rs 5, rt 2, rd 11, car_write 1, out_valid 1.
- LW 9'b001_00_10_00 then ADD 9'b010_00_10_01 with out_ready = 1:
  - LW on output; `in_ready` = 0 for one cycle;
  - one bubble;
  - then ADD with rt 2.
- `out_ready` = 0 for 3 cycles with ADDI 9'b011_00_00_11 on output → fields stable (imm 3, sel_imm 1); `in_ready` = 0; no instruction lost.
- HALT 9'b111_00_00_11 → halt 1 on output; `halted` = 1; `in_ready` = 0 for 10 cycles despite `in_valid` = 1.
- Illegal 9'b001_00_00_10 → illegal 1, all write enables 0.
- Assert `rst_n` low while output valid and stalled → `out_valid` and `halted` = 0 immediately; normal accept after release.
